// File: rtl/y86_fetch_unit.sv
// Y86-64 SEQ fetch stage with a run-time loadable byte-wide instruction memory.
// Decodes one variable-length instruction per unstalled cycle and advances the PC.
module y86_fetch_unit #(
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 10,
    parameter int XLEN     = 64,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [7:0]        imem_wdata,
    input  logic              stall,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_new,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [XLEN-1:0]   valC,
    output logic [XLEN-1:0]   valP,
    output logic [2:0]        stat,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Extra headroom bits so PC + length never wraps before the range check.
    localparam int WIDE = ADDR_W + 4;

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t state, state_next;

    logic [7:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (imem_we && ({1'b0, imem_waddr} < (ADDR_W+1)'(DEPTH))) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    logic [WIDE-1:0] pc_wide;
    logic [7:0]      fbyte [0:9];

    assign pc_wide = WIDE'(pc);

    // Bytes past the end of memory read as zero rather than wrapping around.
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            if ((pc_wide + WIDE'(i)) < WIDE'(DEPTH)) begin
                fbyte[i] = mem[ADDR_W'(pc_wide + WIDE'(i))];
            end else begin
                fbyte[i] = 8'h00;
            end
        end
    end

    logic [3:0]      d_icode;
    logic [3:0]      d_ifun;
    logic [3:0]      d_len;
    logic            d_has_regs;
    logic            d_has_valc;
    logic            d_ins;
    logic [3:0]      d_rA;
    logic [3:0]      d_rB;
    logic [63:0]     d_valc_raw;
    logic [WIDE-1:0] d_end;
    logic            d_adr;
    logic [2:0]      d_stat;

    assign d_icode = fbyte[0][7:4];
    assign d_ifun  = fbyte[0][3:0];

    always_comb begin
        d_len      = 4'd1;
        d_has_regs = 1'b0;
        d_has_valc = 1'b0;
        d_ins      = 1'b0;
        case (d_icode)
            4'h0, 4'h1, 4'h9: begin
                d_len = 4'd1;
                d_ins = (d_ifun != 4'h0);
            end
            4'h2: begin
                d_len      = 4'd2;
                d_has_regs = 1'b1;
                d_ins      = (d_ifun > 4'h6);
            end
            4'h6: begin
                d_len      = 4'd2;
                d_has_regs = 1'b1;
                d_ins      = (d_ifun > 4'h3);
            end
            4'hA, 4'hB: begin
                d_len      = 4'd2;
                d_has_regs = 1'b1;
                d_ins      = (d_ifun != 4'h0);
            end
            4'h7: begin
                d_len      = 4'd9;
                d_has_valc = 1'b1;
                d_ins      = (d_ifun > 4'h6);
            end
            4'h8: begin
                d_len      = 4'd9;
                d_has_valc = 1'b1;
                d_ins      = (d_ifun != 4'h0);
            end
            4'h3, 4'h4, 4'h5: begin
                d_len      = 4'd10;
                d_has_regs = 1'b1;
                d_has_valc = 1'b1;
                d_ins      = (d_ifun != 4'h0);
            end
            default: begin
                d_len = 4'd1;
                d_ins = 1'b1;
            end
        endcase
    end

    // valC is little-endian and starts right after the register byte when present.
    always_comb begin
        d_rA       = 4'hF;
        d_rB       = 4'hF;
        d_valc_raw = 64'd0;
        if (d_has_regs) begin
            d_rA = fbyte[1][7:4];
            d_rB = fbyte[1][3:0];
        end
        if (d_has_valc) begin
            if (d_has_regs) begin
                d_valc_raw = {fbyte[9], fbyte[8], fbyte[7], fbyte[6],
                              fbyte[5], fbyte[4], fbyte[3], fbyte[2]};
            end else begin
                d_valc_raw = {fbyte[8], fbyte[7], fbyte[6], fbyte[5],
                              fbyte[4], fbyte[3], fbyte[2], fbyte[1]};
            end
        end
    end

    assign d_end = pc_wide + WIDE'(d_len);
    assign d_adr = (d_end - WIDE'(1)) >= WIDE'(DEPTH);

    always_comb begin
        if (d_ins) begin
            d_stat = STAT_INS;
        end else if (d_adr) begin
            d_stat = STAT_ADR;
        end else if (d_icode == 4'h0) begin
            d_stat = STAT_HLT;
        end else begin
            d_stat = STAT_AOK;
        end
    end

    logic fetch_en;
    logic redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (pc_load) begin
            state_next = RUN;
        end else if (!stall && (state == RUN) && (d_stat != STAT_AOK)) begin
            state_next = HALT;
        end
    end

    always_comb begin
        redirect = pc_load;
        fetch_en = (state == RUN) && !stall && !pc_load;
    end

    // A faulting fetch keeps its fields visible but is never flagged valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= ADDR_W'(RESET_PC);
            icode       <= 4'h0;
            ifun        <= 4'h0;
            rA          <= 4'hF;
            rB          <= 4'hF;
            valC        <= '0;
            valP        <= '0;
            stat        <= STAT_AOK;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            pc          <= pc_new;
            instr_valid <= 1'b0;
            stat        <= STAT_AOK;
        end else if (fetch_en) begin
            icode       <= d_icode;
            ifun        <= d_ifun;
            rA          <= d_rA;
            rB          <= d_rB;
            valC        <= XLEN'(d_valc_raw);
            valP        <= XLEN'(d_end);
            stat        <= d_stat;
            instr_valid <= (d_stat == STAT_AOK);
            if (d_stat == STAT_AOK) begin
                pc <= ADDR_W'(d_end);
            end
        end
    end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Directed self-checking bench for y86_fetch_unit: loads small programs and
// checks the registered fetch outputs cycle by cycle against hand-computed values.
module tb_y86_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [7:0]  imem_wdata;
    logic        stall;
    logic        pc_load;
    logic [9:0]  pc_new;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [2:0]  stat;
    logic        instr_valid;
    logic [9:0]  pc;

    int compared;
    int mismatched;

    y86_fetch_unit #(
        .DEPTH   (1024),
        .ADDR_W  (10),
        .XLEN    (64),
        .RESET_PC(0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .stall      (stall),
        .pc_load    (pc_load),
        .pc_new     (pc_new),
        .icode      (icode),
        .ifun       (ifun),
        .rA         (rA),
        .rB         (rB),
        .valC       (valC),
        .valP       (valP),
        .stat       (stat),
        .instr_valid(instr_valid),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the control inputs, take one clock edge, and settle 1ns after it.
    task automatic applyStimulus(input logic st, input logic ld, input logic [9:0] tgt);
        stall   = st;
        pc_load = ld;
        pc_new  = tgt;
        @(posedge clk);
        #1;
        stall   = 1'b0;
        pc_load = 1'b0;
    endtask

    task automatic writeByte(input logic [9:0] addr, input logic [7:0] data);
        imem_we    = 1'b1;
        imem_waddr = addr;
        imem_wdata = data;
        @(posedge clk);
        #1;
        imem_we = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        imem_we    = 1'b0;
        imem_waddr = '0;
        imem_wdata = '0;
        stall      = 1'b0;
        pc_load    = 1'b0;
        pc_new     = '0;

        // irmovq $5,%rdx then halt
        $display("[TB] irmovq + halt");
        writeByte(10'd0, 8'h30);
        writeByte(10'd1, 8'hF2);
        writeByte(10'd2, 8'h05);
        for (int a = 3; a <= 10; a++) writeByte(10'(a), 8'h00);
        checkOutput("rst_pc", 64'(pc), 64'd0);
        checkOutput("rst_icode", 64'(icode), 64'd0);
        checkOutput("rst_rA", 64'(rA), 64'hF);
        checkOutput("rst_rB", 64'(rB), 64'hF);
        checkOutput("rst_valC", valC, 64'd0);
        checkOutput("rst_valP", valP, 64'd0);
        checkOutput("rst_stat", 64'(stat), 64'd1);
        checkOutput("rst_valid", 64'(instr_valid), 64'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("irm_icode", 64'(icode), 64'd3);
        checkOutput("irm_ifun", 64'(ifun), 64'd0);
        checkOutput("irm_rA", 64'(rA), 64'hF);
        checkOutput("irm_rB", 64'(rB), 64'd2);
        checkOutput("irm_valC", valC, 64'd5);
        checkOutput("irm_valP", valP, 64'd10);
        checkOutput("irm_stat", 64'(stat), 64'd1);
        checkOutput("irm_valid", 64'(instr_valid), 64'd1);
        checkOutput("irm_pc", 64'(pc), 64'd10);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("hlt_icode", 64'(icode), 64'd0);
        checkOutput("hlt_stat", 64'(stat), 64'd2);
        checkOutput("hlt_valP", valP, 64'd11);
        checkOutput("hlt_valid", 64'(instr_valid), 64'd0);
        checkOutput("hlt_pc", 64'(pc), 64'd10);
        applyStimulus(1'b0, 1'b0, 10'd0);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("hlt_pc_hold", 64'(pc), 64'd10);
        checkOutput("hlt_stat_hold", 64'(stat), 64'd2);
        checkOutput("hlt_valid_hold", 64'(instr_valid), 64'd0);

        // OPq %rcx,%rdx then jmp 0x20, redirected by pc_load
        $display("[TB] OPq + jXX + redirect");
        rst_n = 1'b0;
        writeByte(10'd0, 8'h60);
        writeByte(10'd1, 8'h12);
        writeByte(10'd2, 8'h70);
        writeByte(10'd3, 8'h20);
        for (int a = 4; a <= 10; a++) writeByte(10'(a), 8'h00);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("opq_icode", 64'(icode), 64'd6);
        checkOutput("opq_rA", 64'(rA), 64'd1);
        checkOutput("opq_rB", 64'(rB), 64'd2);
        checkOutput("opq_valC", valC, 64'd0);
        checkOutput("opq_valP", valP, 64'd2);
        checkOutput("opq_pc", 64'(pc), 64'd2);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("jxx_icode", 64'(icode), 64'd7);
        checkOutput("jxx_rA", 64'(rA), 64'hF);
        checkOutput("jxx_valC", valC, 64'd32);
        checkOutput("jxx_valP", valP, 64'd11);
        checkOutput("jxx_pc", 64'(pc), 64'd11);
        applyStimulus(1'b0, 1'b1, 10'd32);
        checkOutput("ld_valid", 64'(instr_valid), 64'd0);
        checkOutput("ld_pc", 64'(pc), 64'd32);
        checkOutput("ld_icode_hold", 64'(icode), 64'd7);

        // nop, nop, halt with a three-cycle stall after the first fetch
        $display("[TB] stall");
        rst_n = 1'b0;
        writeByte(10'd0, 8'h10);
        writeByte(10'd1, 8'h10);
        writeByte(10'd2, 8'h00);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("nop_icode", 64'(icode), 64'd1);
        checkOutput("nop_pc", 64'(pc), 64'd1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 10'd0);
            checkOutput("stl_pc", 64'(pc), 64'd1);
            checkOutput("stl_valid", 64'(instr_valid), 64'd1);
            checkOutput("stl_valP", valP, 64'd1);
            checkOutput("stl_icode", 64'(icode), 64'd1);
        end
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("stl_rel_pc", 64'(pc), 64'd2);
        checkOutput("stl_rel_valP", valP, 64'd2);
        checkOutput("stl_rel_valid", 64'(instr_valid), 64'd1);

        // invalid icode C at 4, resume at 0, then OPq with ifun out of range
        $display("[TB] invalid instruction");
        rst_n = 1'b0;
        writeByte(10'd0, 8'h10);
        writeByte(10'd1, 8'h64);
        writeByte(10'd2, 8'h12);
        writeByte(10'd4, 8'hC0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 10'd4);
        checkOutput("ins_ld_pc", 64'(pc), 64'd4);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("ins_stat", 64'(stat), 64'd4);
        checkOutput("ins_icode", 64'(icode), 64'hC);
        checkOutput("ins_valid", 64'(instr_valid), 64'd0);
        checkOutput("ins_pc", 64'(pc), 64'd4);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("ins_pc_hold", 64'(pc), 64'd4);
        checkOutput("ins_stat_hold", 64'(stat), 64'd4);
        applyStimulus(1'b0, 1'b1, 10'd0);
        checkOutput("rsm_stat", 64'(stat), 64'd1);
        checkOutput("rsm_pc", 64'(pc), 64'd0);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("rsm_icode", 64'(icode), 64'd1);
        checkOutput("rsm_valid", 64'(instr_valid), 64'd1);
        checkOutput("rsm_pc2", 64'(pc), 64'd1);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("ifun_stat", 64'(stat), 64'd4);
        checkOutput("ifun_ifun", 64'(ifun), 64'd4);
        checkOutput("ifun_pc", 64'(pc), 64'd1);

        // irmovq straddling the end of memory, then write + redirect same cycle
        $display("[TB] address error");
        rst_n = 1'b0;
        writeByte(10'd1020, 8'h30);
        writeByte(10'd1021, 8'hF2);
        writeByte(10'd1022, 8'h00);
        writeByte(10'd1023, 8'h00);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 10'd1020);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("adr_stat", 64'(stat), 64'd3);
        checkOutput("adr_pc", 64'(pc), 64'd1020);
        checkOutput("adr_valP", valP, 64'd1030);
        checkOutput("adr_valid", 64'(instr_valid), 64'd0);
        imem_we    = 1'b1;
        imem_waddr = 10'd1020;
        imem_wdata = 8'h10;
        applyStimulus(1'b0, 1'b1, 10'd1020);
        imem_we = 1'b0;
        checkOutput("wld_pc", 64'(pc), 64'd1020);
        checkOutput("wld_stat", 64'(stat), 64'd1);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("wld_icode", 64'(icode), 64'd1);
        checkOutput("wld_stat2", 64'(stat), 64'd1);
        checkOutput("wld_valP", valP, 64'd1021);
        checkOutput("wld_pc2", 64'(pc), 64'd1021);

        // reset during a stall, then re-execute the preserved program
        $display("[TB] reset under stall");
        rst_n = 1'b0;
        writeByte(10'd0, 8'h60);
        writeByte(10'd1, 8'h12);
        writeByte(10'd2, 8'h60);
        writeByte(10'd3, 8'h34);
        writeByte(10'd4, 8'h00);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("r1_pc", 64'(pc), 64'd2);
        applyStimulus(1'b1, 1'b0, 10'd0);
        checkOutput("r1_stall_pc", 64'(pc), 64'd2);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 10'd0);
        rst_n = 1'b1;
        checkOutput("rs_pc", 64'(pc), 64'd0);
        checkOutput("rs_rA", 64'(rA), 64'hF);
        checkOutput("rs_rB", 64'(rB), 64'hF);
        checkOutput("rs_stat", 64'(stat), 64'd1);
        checkOutput("rs_valid", 64'(instr_valid), 64'd0);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("r2_rA", 64'(rA), 64'd1);
        checkOutput("r2_rB", 64'(rB), 64'd2);
        checkOutput("r2_pc", 64'(pc), 64'd2);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("r3_rA", 64'(rA), 64'd3);
        checkOutput("r3_rB", 64'(rB), 64'd4);
        checkOutput("r3_pc", 64'(pc), 64'd4);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("r4_stat", 64'(stat), 64'd2);
        checkOutput("r4_pc", 64'(pc), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
